// File: rtl/frame_buffer_writer_pkg.sv
// Shared types and helpers for the frame-buffer writer.
package frame_buffer_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    WRITE
  } state_e;

  function automatic int unsigned num_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  function automatic int unsigned count_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// Pixel index within the current frame; clear and increment may combine to load 1.
module frame_pixel_counter #(
  parameter int unsigned NUM_PIXELS = 8,
  parameter int unsigned CW         = 3
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_is_last
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = i_clear ? '0 : count_q;
    if (i_inc) count_d = count_d + CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) count_q <= '0;
    else            count_q <= count_d;
  end

  assign o_is_last = (count_q == CW'(NUM_PIXELS - 1));

endmodule

// File: rtl/frame_buffer_writer.sv
// Writes a valid-qualified pixel stream with SOF into single or ping-pong frame buffers.
module frame_buffer_writer
  import frame_buffer_writer_pkg::*;
#(
  parameter int unsigned WIDTH_IMAGE   = 640,
  parameter int unsigned HEIGHT_IMAGE  = 480,
  parameter int unsigned NUM_CHANNELS  = 3,
  parameter int unsigned COLOR_CHANNEL = 8,
  parameter int unsigned NUM_BUFFERS   = 2,
  parameter int unsigned ADDR_WIDTH    = 20,
  parameter int unsigned MAX_ADDRESS   = NUM_BUFFERS * WIDTH_IMAGE * HEIGHT_IMAGE - 1
) (
  input  logic                                         i_clk,
  input  logic                                         i_reset_n,
  input  logic                                         i_enable,
  input  logic                                         i_sof,
  input  logic                                         i_data_valid,
  input  logic [NUM_CHANNELS-1:0][COLOR_CHANNEL-1:0]   i_data,
  output logic                                         o_wr_enable,
  output logic [ADDR_WIDTH-1:0]                        o_wr_address,
  output logic [NUM_CHANNELS-1:0][COLOR_CHANNEL-1:0]   o_data,
  output logic                                         o_active_buffer,
  output logic                                         o_frame_done,
  output logic                                         o_err_short,
  output logic                                         o_err_long,
  output logic                                         o_busy
);

  localparam int unsigned NP = num_pixels(WIDTH_IMAGE, HEIGHT_IMAGE);
  localparam int unsigned CW = count_width(NP);
  localparam logic [ADDR_WIDTH-1:0] BASE1 = ADDR_WIDTH'(NP);
  localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(MAX_ADDRESS);
  localparam logic ONE_PIXEL = (NP == 1);
  localparam logic PING_PONG = (NUM_BUFFERS == 2);

  typedef logic [NUM_CHANNELS-1:0][COLOR_CHANNEL-1:0] pixel_t;

  if (NUM_BUFFERS != 1 && NUM_BUFFERS != 2) begin : g_bad_buffers
    $error("NUM_BUFFERS must be 1 or 2");
  end
  if (ADDR_WIDTH < $clog2(NUM_BUFFERS * NP)) begin : g_bad_addr
    $error("ADDR_WIDTH too small for the frame buffers");
  end

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  pixel_t                data_q, data_d;
  logic                  done_q, done_d;
  logic                  es_q, es_d;
  logic                  el_q, el_d;
  logic                  buf_q, buf_d;
  logic                  write, last, cnt_last, cnt_clear, cnt_inc;
  logic [ADDR_WIDTH-1:0] base;

  frame_pixel_counter #(
    .NUM_PIXELS(NP),
    .CW        (CW)
  ) u_counter (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clear  (cnt_clear),
    .i_inc    (cnt_inc),
    .o_is_last(cnt_last)
  );

  assign base = buf_q ? BASE1 : '0;

  always_comb begin
    state_d   = state_q;
    valid_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    es_d      = 1'b0;
    el_d      = 1'b0;
    buf_d     = buf_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    write     = 1'b0;
    last      = 1'b0;

    case (state_q)
      IDLE: if (i_enable) state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (!i_enable) state_d = IDLE;
        else if (i_data_valid) begin
          if (i_sof) begin
            write   = 1'b1;
            state_d = WRITE;
          end else begin
            el_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (i_data_valid) begin
          write = 1'b1;
          es_d  = i_sof;
        end
      end
      default: state_d = IDLE;
    endcase

    // An SOF always restarts at pixel 0 of the current buffer, even mid-frame.
    if (write) begin
      last      = i_sof ? ONE_PIXEL : cnt_last;
      valid_d   = 1'b1;
      data_d    = i_data;
      addr_d    = i_sof ? base : addr_q + ADDR_WIDTH'(1);
      cnt_clear = i_sof | last;
      cnt_inc   = !last;
      if (last) begin
        done_d  = !es_d;
        buf_d   = PING_PONG ? ~buf_q : 1'b0;
        state_d = i_enable ? WAIT_SOF : IDLE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      es_q    <= 1'b0;
      el_q    <= 1'b0;
      buf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      es_q    <= es_d;
      el_q    <= el_d;
      buf_q   <= buf_d;
    end
  end

  assign o_wr_enable     = valid_q & (addr_q <= MAX_A);
  assign o_wr_address    = addr_q;
  assign o_data          = data_q;
  assign o_active_buffer = buf_q;
  assign o_frame_done    = done_q;
  assign o_err_short     = es_q;
  assign o_err_long      = el_q;
  assign o_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer with a 4x2 ping-pong frame.
module tb_frame_buffer_writer;

  logic        clk, rst_n, en, sof, valid;
  logic [23:0] data;
  logic        wr_en, act, done, es, el, busy;
  logic [7:0]  addr;
  logic [23:0] odata;
  logic        c_wr_en, c_act, c_done, c_es, c_el, c_busy;
  logic [7:0]  c_addr;
  logic [23:0] c_data;

  int total = 0;
  int bad   = 0;

  frame_buffer_writer #(
    .WIDTH_IMAGE(4), .HEIGHT_IMAGE(2), .NUM_CHANNELS(3), .COLOR_CHANNEL(8),
    .NUM_BUFFERS(2), .ADDR_WIDTH(8)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_sof(sof), .i_data_valid(valid),
    .i_data(data), .o_wr_enable(wr_en), .o_wr_address(addr), .o_data(odata),
    .o_active_buffer(act), .o_frame_done(done), .o_err_short(es), .o_err_long(el),
    .o_busy(busy)
  );

  frame_buffer_writer #(
    .WIDTH_IMAGE(4), .HEIGHT_IMAGE(2), .NUM_CHANNELS(3), .COLOR_CHANNEL(8),
    .NUM_BUFFERS(2), .ADDR_WIDTH(8), .MAX_ADDRESS(5)
  ) dut_clip (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_sof(sof), .i_data_valid(valid),
    .i_data(data), .o_wr_enable(c_wr_en), .o_wr_address(c_addr), .o_data(c_data),
    .o_active_buffer(c_act), .o_frame_done(c_done), .o_err_short(c_es), .o_err_long(c_el),
    .o_busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic px(input logic v, input logic s, input logic [23:0] d);
    valid = v; sof = s; data = d;
    @(posedge clk); #1;
  endtask

  function automatic logic [23:0] pix(input logic [7:0] tag, input int k);
    return {tag, 8'(k), ~8'(k)};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0;
    px(0, 0, 24'h0); px(0, 0, 24'h0);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    total++; if (addr !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr); end
    total++; if (odata !== 24'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", odata); end
    total++; if ({act, done, es, el, busy} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {act, done, es, el, busy}); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    en = 1'b1;
    px(0, 0, 24'h0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        px(1, k == 0, pix(8'hA0 + 8'(f), k));
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL b2b_wr_en f=%0d k=%0d got=%b exp=1", f, k, wr_en); end
        total++; if (addr !== 8'(f * 8 + k)) begin bad++; $display("FAIL b2b_addr f=%0d k=%0d got=%0d exp=%0d", f, k, addr, f * 8 + k); end
        total++; if (odata !== pix(8'hA0 + 8'(f), k)) begin bad++; $display("FAIL b2b_data f=%0d k=%0d got=%h exp=%h", f, k, odata, pix(8'hA0 + 8'(f), k)); end
        total++; if (done !== (k == 7)) begin bad++; $display("FAIL b2b_done f=%0d k=%0d got=%b exp=%b", f, k, done, k == 7); end
        total++; if (act !== ((f == 1) ^ (k == 7))) begin bad++; $display("FAIL b2b_active f=%0d k=%0d got=%b exp=%b", f, k, act, (f == 1) ^ (k == 7)); end
      end
    end
  endtask

  task automatic test_clip;
    for (int k = 0; k < 8; k++) begin
      px(1, k == 0, pix(8'hB0, k));
      total++; if (c_wr_en !== (k <= 5)) begin bad++; $display("FAIL clip_wr_en k=%0d got=%b exp=%b", k, c_wr_en, k <= 5); end
      total++; if (c_addr !== 8'(k)) begin bad++; $display("FAIL clip_addr k=%0d got=%0d exp=%0d", k, c_addr, k); end
      total++; if (c_done !== (k == 7)) begin bad++; $display("FAIL clip_done k=%0d got=%b exp=%b", k, c_done, k == 7); end
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL clip_full_wr_en k=%0d got=%b exp=1", k, wr_en); end
    end
    total++; if (c_act !== 1'b1) begin bad++; $display("FAIL clip_active got=%b exp=1", c_act); end
  endtask

  task automatic test_gaps;
    for (int k = 0; k < 8; k++) begin
      px(1, k == 0, pix(8'hC0, k));
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL gaps_wr_en k=%0d got=%b exp=1", k, wr_en); end
      total++; if (addr !== 8'(8 + k)) begin bad++; $display("FAIL gaps_addr k=%0d got=%0d exp=%0d", k, addr, 8 + k); end
      total++; if (odata !== pix(8'hC0, k)) begin bad++; $display("FAIL gaps_data k=%0d got=%h exp=%h", k, odata, pix(8'hC0, k)); end
      total++; if (done !== (k == 7)) begin bad++; $display("FAIL gaps_done k=%0d got=%b exp=%b", k, done, k == 7); end
      for (int g = 0; g < 2; g++) begin
        px(0, 0, 24'hFFFFFF);
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL gaps_idle_wr_en k=%0d got=%b exp=0", k, wr_en); end
        total++; if (addr !== 8'(8 + k)) begin bad++; $display("FAIL gaps_idle_addr k=%0d got=%0d exp=%0d", k, addr, 8 + k); end
        total++; if (odata !== pix(8'hC0, k)) begin bad++; $display("FAIL gaps_idle_data k=%0d got=%h exp=%h", k, odata, pix(8'hC0, k)); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL gaps_idle_done k=%0d got=%b exp=0", k, done); end
      end
    end
    total++; if (act !== 1'b0) begin bad++; $display("FAIL gaps_active got=%b exp=0", act); end
  endtask

  task automatic test_err_long;
    for (int k = 0; k < 3; k++) begin
      px(1, 0, 24'h123456);
      total++; if (el !== 1'b1) begin bad++; $display("FAIL long_err k=%0d got=%b exp=1", k, el); end
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL long_wr_en k=%0d got=%b exp=0", k, wr_en); end
    end
    for (int k = 0; k < 8; k++) begin
      px(1, k == 0, pix(8'hD0, k));
      total++; if (el !== 1'b0) begin bad++; $display("FAIL long_err_clear k=%0d got=%b exp=0", k, el); end
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL long_frame_wr_en k=%0d got=%b exp=1", k, wr_en); end
      total++; if (addr !== 8'(k)) begin bad++; $display("FAIL long_frame_addr k=%0d got=%0d exp=%0d", k, addr, k); end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL long_frame_done got=%b exp=1", done); end
  endtask

  task automatic test_short;
    for (int k = 0; k < 5; k++) begin
      px(1, k == 0, pix(8'hE0, k));
      total++; if (addr !== 8'(8 + k)) begin bad++; $display("FAIL short_pre_addr k=%0d got=%0d exp=%0d", k, addr, 8 + k); end
    end
    px(1, 1, pix(8'hE1, 0));
    total++; if (es !== 1'b1) begin bad++; $display("FAIL short_err got=%b exp=1", es); end
    total++; if (addr !== 8'd8) begin bad++; $display("FAIL short_restart_addr got=%0d exp=8", addr); end
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL short_restart_wr_en got=%b exp=1", wr_en); end
    total++; if (odata !== pix(8'hE1, 0)) begin bad++; $display("FAIL short_restart_data got=%h exp=%h", odata, pix(8'hE1, 0)); end
    total++; if ({done, act} !== 2'b01) begin bad++; $display("FAIL short_restart_done_act got=%b exp=01", {done, act}); end
    for (int j = 1; j < 8; j++) begin
      px(1, 0, pix(8'hE1, j));
      total++; if (es !== 1'b0) begin bad++; $display("FAIL short_err_clear j=%0d got=%b exp=0", j, es); end
      total++; if (addr !== 8'(8 + j)) begin bad++; $display("FAIL short_addr j=%0d got=%0d exp=%0d", j, addr, 8 + j); end
      total++; if (done !== (j == 7)) begin bad++; $display("FAIL short_done j=%0d got=%b exp=%b", j, done, j == 7); end
      total++; if (act !== (j != 7)) begin bad++; $display("FAIL short_active j=%0d got=%b exp=%b", j, act, j != 7); end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 8; k++) px(1, k == 0, pix(8'hF0, k));
    total++; if (act !== 1'b1) begin bad++; $display("FAIL rmid_active_pre got=%b exp=1", act); end
    for (int k = 0; k < 3; k++) begin
      px(1, k == 0, pix(8'hF1, k));
      total++; if (addr !== 8'(8 + k)) begin bad++; $display("FAIL rmid_pre_addr k=%0d got=%0d exp=%0d", k, addr, 8 + k); end
    end
    rst_n = 1'b0;
    px(1, 0, pix(8'hF1, 3));
    total++; if ({wr_en, act, done, es, el, busy} !== 6'b0) begin bad++; $display("FAIL rmid_flags got=%b exp=000000", {wr_en, act, done, es, el, busy}); end
    total++; if (addr !== 8'd0) begin bad++; $display("FAIL rmid_addr got=%0d exp=0", addr); end
    total++; if (odata !== 24'd0) begin bad++; $display("FAIL rmid_data got=%h exp=0", odata); end
    rst_n = 1'b1;
    px(0, 0, 24'h0);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) en = 1'b0;
      px(1, k == 0, pix(8'hF2, k));
      total++; if (addr !== 8'(k)) begin bad++; $display("FAIL rmid_addr k=%0d got=%0d exp=%0d", k, addr, k); end
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL rmid_wr_en k=%0d got=%b exp=1", k, wr_en); end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rmid_done got=%b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_idle_after_disable got=%b exp=0", busy); end
    total++; if (act !== 1'b1) begin bad++; $display("FAIL rmid_active_post got=%b exp=1", act); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sof = 1'b0; valid = 1'b0; data = '0;
    #1;
    test_reset();
    test_back_to_back();
    test_clip();
    test_gaps();
    test_err_long();
    test_short();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
